crc_par_engine: RTL and testbench
=================================

CRC_PAR_ENGINE -- requirements
Module: crc_par_engine

Interface
REQ-001 SHALL have parameter CRC_WD, default 8, meaning CRC register width in bits (2..32).
REQ-002 SHALL have parameter IN_WD, default 1, meaning data bits accepted per cycle (1, 2, 4 or 8).
REQ-003 SHALL have parameter POLY, default 'h8C, meaning polynomial in reflected (LSB-first) form, CRC_WD bits.
REQ-004 SHALL have parameter SEED, default 'h00, meaning CRC register value loaded at frame start.
REQ-005 SHALL have port CLK, input, 1, meaning the single clock; all logic on rising edge.
REQ-006 SHALL have port RST, input, 1, meaning reset, synchronous and active-high.
REQ-007 SHALL have port Active, input, 1, meaning DATA is valid this cycle and the frame continues.
REQ-008 SHALL have port DATA, input, IN_WD, meaning frame data, with bit 0 consumed first.
REQ-009 SHALL have port CRC, output, 1, meaning serial CRC bit, LSB first.
REQ-010 SHALL have port Valid, output, 1, meaning CRC carries a result bit this cycle.
REQ-011 SHALL have port Busy, output, 1, meaning a frame is being absorbed or its CRC is being emitted.

Function
REQ-012 SHALL implement FSM states IDLE, ABSORB and EMIT, all outputs registered.
REQ-013 IDLE with Active=1 SHALL load SEED, fold the DATA lane into the register in the same cycle and go to ABSORB.
REQ-014 ABSORB with Active=1 SHALL fold DATA each cycle, with no limit on frame length.
REQ-015 Per bit b, folding SHALL be: fb=b^r[0]; r=(r>>1)^(fb?POLY:0), applied IN_WD times per cycle in lane order.
REQ-016 ABSORB with Active=0 SHALL go to EMIT and latch the final register into the output shifter.
REQ-017 EMIT SHALL drive Valid=1 and CRC=shifter[0] for exactly CRC_WD cycles, shifting right each cycle, then return to IDLE.
REQ-018 The first Valid=1 cycle SHALL begin one clock edge after the edge that sampled Active=0.
REQ-019 Active=1 during EMIT SHALL be ignored; a new frame starts only when Active=1 is sampled in IDLE.
REQ-020 A one-cycle Active pulse SHALL form a valid one-lane frame.
REQ-021 Busy SHALL be 1 in ABSORB and EMIT and 0 in IDLE.
REQ-022 The EMIT bit counter SHALL be $clog2(CRC_WD+1) bits wide and SHALL not wrap within a frame.

Reset
REQ-023 RST=1 at a clock edge SHALL force IDLE, register=SEED, shifter=0, CRC=0, Valid=0 and Busy=0, taking priority over Active.
REQ-024 RST asserted mid-ABSORB or mid-EMIT SHALL abort the frame with no further Valid cycles.

Configuration
REQ-025 With macro CRC_FINAL_XOR_EN defined, parameter XOR_OUT (default 'hFF) SHALL be XORed into the result when it is latched for EMIT.
REQ-026 Without CRC_FINAL_XOR_EN, XOR_OUT SHALL not exist and the result SHALL be emitted unmodified.

Structure
REQ-027 Package crc_pkg SHALL hold the FSM state typedef and the default POLY/SEED/CRC_WD constants.
REQ-028 The combinational IN_WD-bit fold SHALL be the sub-module crc_lfsr_step, instantiated once.

Verification
REQ-029 Defaults, IN_WD=1, serial 0x01 LSB first -> Valid after 8 data cycles, serial CRC 0x5E.
REQ-030 IN_WD=8, bytes "123456789" (0x31..0x39) over 9 cycles -> CRC 0xA1, Valid high for exactly 8 cycles.
REQ-031 CRC_FINAL_XOR_EN with XOR_OUT='hFF, 0x01 -> emitted 0xA1; without the macro -> 0x5E.
REQ-032 RST pulsed on the 3rd EMIT cycle -> Valid=0 and Busy=0 the next cycle; the following 0x01 frame -> 0x5E.
REQ-033 Active held high across EMIT after frame 0x01 -> result 0x5E unaffected and no frame starts until IDLE.
REQ-034 Back-to-back frames 0x00 then 0x01 (SEED=0) -> 0x00 then 0x5E, with Busy low for one cycle between them.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared FSM state type and default CRC-8/MAXIM constants for the parallel CRC engine.
package crc_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ABSORB = 2'd1,
    EMIT   = 2'd2
  } crc_state_e;

  localparam int          CRC_WD_DEF  = 8;
  localparam logic [31:0] POLY_DEF    = 32'h0000_008C;
  localparam logic [31:0] SEED_DEF    = 32'h0000_0000;
  localparam logic [31:0] XOR_OUT_DEF = 32'h0000_00FF;
endpackage

// File: rtl/crc_lfsr_step.sv
// Combinational fold of IN_WD data bits into a reflected CRC register, bit 0 first.
module crc_lfsr_step #(
  parameter int                CRC_WD = 8,
  parameter int                IN_WD  = 1,
  parameter logic [CRC_WD-1:0] POLY   = '0
) (
  input  logic [CRC_WD-1:0] crc_in,
  input  logic [IN_WD-1:0]  data,
  output logic [CRC_WD-1:0] crc_out
);
  logic [CRC_WD-1:0] chain [IN_WD+1];

  assign chain[0] = crc_in;

  for (genvar g = 0; g < IN_WD; g++) begin : g_bit
    logic fb;
    assign fb           = data[g] ^ chain[g][0];
    assign chain[g+1]   = (chain[g] >> 1) ^ (fb ? POLY : '0);
  end

  assign crc_out = chain[IN_WD];
endmodule

// File: rtl/crc_par_engine.sv
// Frame CRC engine: absorbs IN_WD bits/cycle, then emits the CRC serially LSB first.
// Optional macro CRC_FINAL_XOR_EN adds parameter XOR_OUT applied to the latched result.
module crc_par_engine
  import crc_pkg::*;
#(
  parameter int                CRC_WD  = CRC_WD_DEF,
  parameter int                IN_WD   = 1,
  parameter logic [CRC_WD-1:0] POLY    = CRC_WD'(POLY_DEF),
  parameter logic [CRC_WD-1:0] SEED    = CRC_WD'(SEED_DEF)
`ifdef CRC_FINAL_XOR_EN
  ,
  parameter logic [CRC_WD-1:0] XOR_OUT = CRC_WD'(XOR_OUT_DEF)
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Active,
  input  logic [IN_WD-1:0] DATA,
  output logic             CRC,
  output logic             Valid,
  output logic             Busy
);
  localparam int CW = $clog2(CRC_WD + 1);

  crc_state_e        state, state_nx;
  logic [CRC_WD-1:0] crc_r, sh, step_in, step_out, result;
  logic [CW-1:0]     cnt;
  logic              emit_done;

  // A frame's first lane folds into SEED directly, so IDLE feeds the seed.
  assign step_in   = (state == IDLE) ? SEED : crc_r;
  assign emit_done = (cnt == CW'(CRC_WD));

`ifdef CRC_FINAL_XOR_EN
  assign result = crc_r ^ XOR_OUT;
`else
  assign result = crc_r;
`endif

  crc_lfsr_step #(
    .CRC_WD (CRC_WD),
    .IN_WD  (IN_WD),
    .POLY   (POLY)
  ) u_step (
    .crc_in  (step_in),
    .data    (DATA),
    .crc_out (step_out)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Active)    state_nx = ABSORB;
      ABSORB:  if (!Active)   state_nx = EMIT;
      EMIT:    if (emit_done) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      crc_r <= SEED;
      sh    <= '0;
      cnt   <= '0;
      CRC   <= 1'b0;
      Valid <= 1'b0;
      Busy  <= 1'b0;
    end else begin
      state <= state_nx;
      Busy  <= (state_nx != IDLE);
      Valid <= 1'b0;
      CRC   <= 1'b0;
      case (state)
        IDLE: begin
          if (Active) crc_r <= step_out;
        end
        ABSORB: begin
          if (Active) begin
            crc_r <= step_out;
          end else begin
            sh  <= result;
            cnt <= '0;
          end
        end
        EMIT: begin
          // Active is ignored here; the counter stops at CRC_WD and never wraps.
          if (!emit_done) begin
            Valid <= 1'b1;
            CRC   <= sh[0];
            sh    <= sh >> 1;
            cnt   <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_par_engine.sv
// Directed bench for crc_par_engine: serial (IN_WD=1) and byte-wide (IN_WD=8) instances.
module tb_crc_par_engine;
`ifdef CRC_FINAL_XOR_EN
  localparam logic [7:0] XO = 8'hFF;
`else
  localparam logic [7:0] XO = 8'h00;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       a_act;
  logic [0:0] a_dat;
  logic       a_crc, a_valid, a_busy;
  logic       b_act;
  logic [7:0] b_dat;
  logic       b_crc, b_valid, b_busy;

  logic       sel;
  logic       cur_valid, cur_crc, cur_busy;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 CLK = ~CLK;

  assign cur_valid = sel ? b_valid : a_valid;
  assign cur_crc   = sel ? b_crc   : a_crc;
  assign cur_busy  = sel ? b_busy  : a_busy;

  crc_par_engine #(.IN_WD(1)) u_a (
    .CLK(CLK), .RST(RST), .Active(a_act), .DATA(a_dat),
    .CRC(a_crc), .Valid(a_valid), .Busy(a_busy)
  );

  crc_par_engine #(.IN_WD(8)) u_b (
    .CLK(CLK), .RST(RST), .Active(b_act), .DATA(b_dat),
    .CRC(b_crc), .Valid(b_valid), .Busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Eight serial bits LSB first, then one edge sampling Active=0.
  task automatic send_a(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      a_act = 1'b1;
      a_dat = b[i];
      tick();
    end
    a_act = 1'b0;
    a_dat = '0;
    tick();
  endtask

  // Called just after the edge that sampled Active=0; fixed cycle budget.
  task automatic get_crc(input string tag, input logic [7:0] exp);
    logic [7:0] val;
    int         nv;
    val = '0;
    nv  = 0;
    chk($sformatf("%s_lat", tag), 32'(cur_valid), 32'd0);
    chk($sformatf("%s_busy_emit", tag), 32'(cur_busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cur_valid) begin
        val[i] = cur_crc;
        nv++;
      end
    end
    tick();
    chk($sformatf("%s_vcnt", tag), 32'(nv), 32'd8);
    chk($sformatf("%s_crc", tag), 32'(val), 32'(exp));
    chk($sformatf("%s_done_v", tag), 32'(cur_valid), 32'd0);
    chk($sformatf("%s_done_busy", tag), 32'(cur_busy), 32'd0);
  endtask

  initial begin
    int nv;
    RST = 1'b1; a_act = 1'b1; a_dat = 1'b1; b_act = 1'b1; b_dat = 8'hFF; sel = 1'b0;

    // Reset wins over Active
    tick(); tick();
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_a_busy",  32'(a_busy),  32'd0);
    chk("rst_a_crc",   32'(a_crc),   32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_b_busy",  32'(b_busy),  32'd0);
    RST = 1'b0; a_act = 1'b0; a_dat = '0; b_act = 1'b0; b_dat = '0;
    tick();
    chk("idle_a_busy", 32'(a_busy), 32'd0);

    // Serial 0x01
    send_a(8'h01);
    get_crc("a01", 8'h5E ^ XO);

    // Byte-wide "123456789"
    sel = 1'b1;
    for (int k = 0; k < 9; k++) begin
      b_act = 1'b1;
      b_dat = 8'h31 + 8'(k);
      tick();
      if (k == 0) chk("b_busy_start", 32'(b_busy), 32'd1);
    end
    b_act = 1'b0;
    b_dat = '0;
    tick();
    get_crc("b123", 8'hA1 ^ XO);
    sel = 1'b0;

    // Reset during the third emitted bit aborts the frame
    send_a(8'h01);
    tick(); tick(); tick();
    chk("abort_pre_v", 32'(a_valid), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_v", 32'(a_valid), 32'd0);
    chk("abort_busy", 32'(a_busy), 32'd0);
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_valid) nv++;
    end
    chk("abort_no_valid", 32'(nv), 32'd0);
    send_a(8'h01);
    get_crc("recov", 8'h5E ^ XO);

    // Active held high through EMIT is ignored; new frame starts once IDLE
    send_a(8'h01);
    a_act = 1'b1;
    a_dat = 1'b1;
    get_crc("hold", 8'h5E ^ XO);
    tick();
    chk("hold_restart_busy", 32'(a_busy), 32'd1);
    for (int i = 1; i < 8; i++) begin
      a_dat = 1'b0;
      tick();
    end
    a_act = 1'b0;
    tick();
    get_crc("hold2", 8'h5E ^ XO);

    // Back-to-back 0x00 then 0x01, one idle cycle between
    send_a(8'h00);
    get_crc("b2b0", 8'h00 ^ XO);
    a_act = 1'b1;
    a_dat = 1'b1;
    tick();
    chk("b2b_busy", 32'(a_busy), 32'd1);
    for (int i = 1; i < 8; i++) begin
      a_dat = 1'b0;
      tick();
    end
    a_act = 1'b0;
    tick();
    get_crc("b2b1", 8'h5E ^ XO);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
